// File: rtl/uart_dac_player.sv
// UART sample receiver feeding a paced R-2R DAC output through a small FIFO.
// Optional 8E1 framing is enabled by defining UART_DAC_PLAYER_PARITY_EN (default build is 8N1).
module uart_dac_player #(
  parameter int RESOLUTION = 12,
  parameter int CLK_FREQ   = 36_750_000,
  parameter int BAUD       = 115_200,
  parameter int DAC_FREQ   = 10_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          rx_i,
  output logic [RESOLUTION-1:0]         dac_o,
  output logic                          dac_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          sync_err_o,
  output logic                          overflow_o,
  output logic                          underrun_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CPS = CLK_FREQ / DAC_FREQ;
  localparam int BW  = $clog2(CPB);
  localparam int SW  = $clog2(CPS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BIT_LAST  = BW'(CPB - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(CPS - 1);
  localparam logic [SW-1:0] SCNT_ONE  = SW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {AS_WAIT_HI, AS_WAIT_LO} as_state_t;

  function automatic logic [RESOLUTION-1:0] f_assemble(input logic [6:0] hi, input logic [6:0] lo);
    logic [13:0] s;
    s = {hi, lo};
    return s[RESOLUTION-1:0];
  endfunction

`ifdef UART_DAC_PLAYER_PARITY_EN
  function automatic logic f_parity_odd(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // input synchroniser; r_rx_d only serves falling-edge detection
  logic r_rx_m, r_rx_s, r_rx_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= rx_i;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  logic w_fall;
  assign w_fall = r_rx_d & ~r_rx_s;

  rx_state_t      r_rx_state;
  logic [BW-1:0]  r_bcnt;
  logic [2:0]     r_bidx;
  logic [7:0]     r_shift;
  logic [7:0]     r_byte;
  logic           r_byte_vld;
  logic           r_frame_err;
`ifdef UART_DAC_PLAYER_PARITY_EN
  logic           r_par;
  logic           r_parity_err;
`endif

  // receiver: byte strobe lands one cycle after the stop-bit sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_state   <= RX_IDLE;
      r_bcnt       <= '0;
      r_bidx       <= '0;
      r_byte_vld   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_DAC_PLAYER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_byte_vld   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_DAC_PLAYER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_rx_state <= RX_START;
            r_bcnt     <= '0;
          end
        end
        RX_START: begin
          if (r_bcnt == HALF_LAST) begin
            r_bcnt     <= '0;
            r_bidx     <= '0;
            r_rx_state <= r_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_bcnt <= r_bcnt + BCNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_bcnt == BIT_LAST) begin
            r_bcnt  <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) begin
`ifdef UART_DAC_PLAYER_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end
          end else begin
            r_bcnt <= r_bcnt + BCNT_ONE;
          end
        end
`ifdef UART_DAC_PLAYER_PARITY_EN
        RX_PARITY: begin
          if (r_bcnt == BIT_LAST) begin
            r_bcnt     <= '0;
            r_par      <= r_rx_s;
            r_rx_state <= RX_STOP;
          end else begin
            r_bcnt <= r_bcnt + BCNT_ONE;
          end
        end
`endif
        RX_STOP: begin
          if (r_bcnt == BIT_LAST) begin
            r_bcnt     <= '0;
            r_rx_state <= RX_IDLE;
            if (!r_rx_s) begin
              r_frame_err <= 1'b1;
`ifdef UART_DAC_PLAYER_PARITY_EN
            end else if (f_parity_odd(r_shift, r_par)) begin
              r_parity_err <= 1'b1;
`endif
            end else begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end
          end else begin
            r_bcnt <= r_bcnt + BCNT_ONE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  as_state_t               r_as_state;
  logic [6:0]              r_hi;
  logic                    r_push;
  logic [RESOLUTION-1:0]   r_push_data;
  logic                    r_sync_err;

  // sample assembler: a high byte always (re)starts a sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_as_state <= AS_WAIT_HI;
      r_push     <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_sync_err <= 1'b0;
      if (r_byte_vld) begin
        if (r_byte[7]) begin
          r_hi       <= r_byte[6:0];
          r_as_state <= AS_WAIT_LO;
        end else if (r_as_state == AS_WAIT_HI) begin
          r_sync_err <= 1'b1;
        end else begin
          r_push      <= 1'b1;
          r_push_data <= f_assemble(r_hi, r_byte[6:0]);
          r_as_state  <= AS_WAIT_HI;
        end
      end
    end
  end

  logic [RESOLUTION-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic [SW-1:0]         r_pcnt;
  logic                  r_primed;
  logic                  w_tick, w_empty, w_full, w_pop, w_wr;

  assign w_tick  = en_i && (r_pcnt == SMP_LAST);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = w_tick && !w_empty;
  assign w_wr    = r_push && (!w_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  // FIFO pointers, pacer and playback outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pcnt      <= '0;
      r_primed    <= 1'b0;
      dac_o       <= '0;
      dac_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      if (!en_i || w_tick) r_pcnt <= '0;
      else                 r_pcnt <= r_pcnt + SCNT_ONE;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        dac_o    <= r_mem[r_rd_ptr];
        r_primed <= 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      dac_valid_o <= w_pop;
      overflow_o  <= r_push && w_full && !w_pop;
      underrun_o  <= w_tick && w_empty && r_primed;
    end
  end

  assign fifo_level_o = r_count;
  assign frame_err_o  = r_frame_err;
  assign sync_err_o   = r_sync_err;
`ifdef UART_DAC_PLAYER_PARITY_EN
  assign parity_err_o = r_parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
